// File: rtl/dsound_pkg.sv
// Shared types, constants and sample scaling for the direct-sound FIFO engine.
package dsound_pkg;

    // Byte sequencer state: IDLE until the first tick finds data in the FIFO.
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    // Each 32-bit FIFO word carries four signed 8-bit PCM samples, byte 0 first.
    localparam int BYTES_PER_WORD = 4;

    // timer_sel encoding.
    localparam logic TSEL_TIMER0 = 1'b0;
    localparam logic TSEL_TIMER1 = 1'b1;

    // Working width for scaling; callers truncate to their OUT_W.
    localparam int SCALE_W = 64;

    // Sign-extend a PCM byte and place it at the top of an out_w-bit word
    // (full volume) or one bit lower (half volume).
    function automatic logic signed [SCALE_W-1:0] scale_sample(
        input logic [7:0] pcm,
        input logic       vol_full,
        input int         out_w
    );
        logic signed [SCALE_W-1:0] ext;
        ext = {{(SCALE_W-8){pcm[7]}}, pcm};
        return vol_full ? (ext <<< (out_w - 8)) : (ext <<< (out_w - 9));
    endfunction

endpackage

// File: rtl/dsound_channel.sv
// One direct-sound channel: word FIFO, byte sequencer, sample scaling and
// DMA refill request. Status outputs exist only when DSOUND_STATUS_EN is defined.
module dsound_channel
    import dsound_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OUT_W = 24
) (
    input  logic                          clk_100,
    input  logic                          reset_n,
    input  logic                          i_wr_en,
    input  logic [31:0]                   i_wr_data,
    input  logic                          i_clear,
    input  logic                          i_enable,
    input  logic                          i_timer_sel,
    input  logic [1:0]                    i_timer_ovf,
    input  logic                          i_vol_full,
    output logic [OUT_W-1:0]              o_sample,
    output logic                          o_valid,
    output logic                          o_req
`ifdef DSOUND_STATUS_EN
   ,output logic [$clog2(DEPTH+1)-1:0]    o_level,
    output logic                          o_underflow,
    output logic                          o_overflow,
    input  logic                          i_status_clr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DEPTH / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_idx;
    seq_state_t       r_state;
    logic [OUT_W-1:0] r_sample;
    logic             r_valid;
    logic             r_req;

    logic             w_tick;
    logic             w_empty;
    logic             w_full;
    logic             w_play;
    logic             w_underflow;
    logic             w_pop;
    logic             w_wr_accept;
    logic [PTR_W-1:0] w_wr_addr;
    logic [31:0]      w_head;
    logic [7:0]       w_pcm;
    logic [CNT_W-1:0] w_count_next;
    seq_state_t       w_state_next;

    assign w_tick  = i_enable & ((i_timer_sel == TSEL_TIMER1) ? i_timer_ovf[1] : i_timer_ovf[0]);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A flush swallows any tick in the same cycle; otherwise a tick either
    // plays the next byte or, with nothing buffered, re-emits the last sample.
    assign w_play      = w_tick & ~i_clear & ~w_empty;
    assign w_underflow = w_tick & ~i_clear & w_empty;
    assign w_pop       = w_play & (r_idx == LAST_IDX);

    // A pop while full frees the slot the write lands in.
    assign w_wr_accept = i_wr_en & (i_clear | ~w_full | w_pop);
    assign w_wr_addr   = i_clear ? '0 : r_wr_ptr;

    assign w_head = r_mem[r_rd_ptr];
    assign w_pcm  = w_head[{r_idx, 3'b000} +: 8];

    // Word count after this cycle's clear, write and pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = CNT_W'(w_wr_accept);
        end else begin
            w_count_next = r_count + CNT_W'(w_wr_accept) - CNT_W'(w_pop);
        end
    end

    // Sequencer next-state: start on the first playable tick, stop when a
    // word boundary finds the FIFO drained.
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (w_play) w_state_next = PLAY;
                PLAY: if (w_underflow || (w_pop && (w_count_next == '0))) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // FIFO pointers, word count and byte index.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
        end else begin
            r_count <= w_count_next;
            if (i_clear) begin
                r_wr_ptr <= PTR_W'(w_wr_accept);
                r_rd_ptr <= '0;
                r_idx    <= '0;
            end else begin
                if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)       r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_play)      r_idx    <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_100) begin
        // NOTE: the sample array is deliberately not reset; the pointers and count decide what is valid.
        if (w_wr_accept) r_mem[w_wr_addr] <= i_wr_data;
    end

    // Output sample, valid strobe and refill request, one cycle after the cause.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
        end else begin
            r_valid <= w_tick & ~i_clear;
            r_req   <= i_clear | (w_pop & (w_count_next <= HALF_CNT));
            if (w_play) r_sample <= OUT_W'(scale_sample(w_pcm, i_vol_full, OUT_W));
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;
    assign o_req    = r_req;

`ifdef DSOUND_STATUS_EN
    logic r_underflow;
    logic r_overflow;
    logic w_overflow;

    assign w_overflow = i_wr_en & ~w_wr_accept;

    // Sticky event flags; an event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_underflow <= w_underflow | (r_underflow & ~i_status_clr);
            r_overflow  <= w_overflow  | (r_overflow  & ~i_status_clr);
        end
    end

    assign o_level     = r_count;
    assign o_underflow = r_underflow;
    assign o_overflow  = r_overflow;
`endif

endmodule

// File: rtl/dsound_fifo_engine.sv
// N-channel direct-sound engine: one dsound_channel per channel.
// Define DSOUND_STATUS_EN to add fifo_level, sticky underflow/overflow flags
// and their status_clr input.
module dsound_fifo_engine
    import dsound_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int OUT_W  = 24
) (
    input  logic                                       clk_100,
    input  logic                                       reset_n,
    input  logic [NUM_CH-1:0]                          wr_en,
    input  logic [NUM_CH-1:0][31:0]                    wr_data,
    input  logic [NUM_CH-1:0]                          fifo_clear,
    input  logic [NUM_CH-1:0]                          enable,
    input  logic [NUM_CH-1:0]                          timer_sel,
    input  logic [1:0]                                 timer_ovf,
    input  logic [NUM_CH-1:0]                          vol_full,
    output logic [NUM_CH-1:0][OUT_W-1:0]               sample_out,
    output logic [NUM_CH-1:0]                          sample_valid,
    output logic [NUM_CH-1:0]                          sound_req
`ifdef DSOUND_STATUS_EN
   ,output logic [NUM_CH-1:0][$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic [NUM_CH-1:0]                          underflow,
    output logic [NUM_CH-1:0]                          overflow,
    input  logic [NUM_CH-1:0]                          status_clr
`endif
);

    // Independent channels sharing only the two timer overflow pulses.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dsound_channel #(
            .DEPTH (DEPTH),
            .OUT_W (OUT_W)
        ) u_ch (
            .clk_100      (clk_100),
            .reset_n      (reset_n),
            .i_wr_en      (wr_en[g]),
            .i_wr_data    (wr_data[g]),
            .i_clear      (fifo_clear[g]),
            .i_enable     (enable[g]),
            .i_timer_sel  (timer_sel[g]),
            .i_timer_ovf  (timer_ovf),
            .i_vol_full   (vol_full[g]),
            .o_sample     (sample_out[g]),
            .o_valid      (sample_valid[g]),
            .o_req        (sound_req[g])
`ifdef DSOUND_STATUS_EN
           ,.o_level      (fifo_level[g]),
            .o_underflow  (underflow[g]),
            .o_overflow   (overflow[g]),
            .i_status_clr (status_clr[g])
`endif
        );
    end

endmodule

// File: tb/tb_dsound_fifo_engine.sv
// Self-checking bench for dsound_fifo_engine: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_dsound_fifo_engine;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam int OUT_W  = 24;

    logic                          clk_100 = 1'b0;
    logic                          reset_n;
    logic [NUM_CH-1:0]             wr_en;
    logic [NUM_CH-1:0][31:0]       wr_data;
    logic [NUM_CH-1:0]             fifo_clear;
    logic [NUM_CH-1:0]             enable;
    logic [NUM_CH-1:0]             timer_sel;
    logic [1:0]                    timer_ovf;
    logic [NUM_CH-1:0]             vol_full;
    logic [NUM_CH-1:0][OUT_W-1:0]  sample_out;
    logic [NUM_CH-1:0]             sample_valid;
    logic [NUM_CH-1:0]             sound_req;
`ifdef DSOUND_STATUS_EN
    logic [NUM_CH-1:0][$clog2(DEPTH+1)-1:0] fifo_level;
    logic [NUM_CH-1:0]             underflow;
    logic [NUM_CH-1:0]             overflow;
    logic [NUM_CH-1:0]             status_clr = '0;
`endif

    always #5 clk_100 = ~clk_100;

    dsound_fifo_engine #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk_100      (clk_100),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_clear   (fifo_clear),
        .enable       (enable),
        .timer_sel    (timer_sel),
        .timer_ovf    (timer_ovf),
        .vol_full     (vol_full),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sound_req    (sound_req)
`ifdef DSOUND_STATUS_EN
       ,.fifo_level   (fifo_level),
        .underflow    (underflow),
        .overflow     (overflow),
        .status_clr   (status_clr)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffered words per channel, byte position in the head
    // word, and the expected registered outputs.
    logic [31:0]      mq      [NUM_CH][$];
    int               m_idx   [NUM_CH];
    logic [OUT_W-1:0] m_last  [NUM_CH];
    logic             m_valid [NUM_CH];
    logic             m_req   [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signed byte times 2^(OUT_W-8) or 2^(OUT_W-9), kept to OUT_W bits.
    function automatic logic [OUT_W-1:0] ref_scale(input logic [7:0] b, input logic vol);
        longint s;
        longint v;
        s = longint'(b);
        if (s >= 128) s -= 256;
        v = s * (vol ? (longint'(1) << (OUT_W - 8)) : (longint'(1) << (OUT_W - 9)));
        return v[OUT_W-1:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_idx[c]   = 0;
            m_last[c]  = '0;
            m_valid[c] = 1'b0;
            m_req[c]   = 1'b0;
        end
    endtask

    // Apply one cycle of inputs to the model.
    task automatic model_update();
        for (int c = 0; c < NUM_CH; c++) begin
            logic        tk;
            logic        popped;
            logic [31:0] w;
            tk = enable[c] && timer_ovf[timer_sel[c]];
            m_valid[c] = 1'b0;
            m_req[c]   = 1'b0;
            popped     = 1'b0;
            if (fifo_clear[c]) begin
                mq[c].delete();
                m_idx[c] = 0;
                m_req[c] = 1'b1;
                if (wr_en[c]) mq[c].push_back(wr_data[c]);
            end else begin
                if (tk) begin
                    m_valid[c] = 1'b1;
                    if (mq[c].size() > 0) begin
                        w = mq[c][0] >> (8 * m_idx[c]);
                        m_last[c] = ref_scale(w[7:0], vol_full[c]);
                        m_idx[c]++;
                        if (m_idx[c] == 4) begin
                            m_idx[c] = 0;
                            void'(mq[c].pop_front());
                            popped = 1'b1;
                        end
                    end
                end
                if (wr_en[c] && mq[c].size() < DEPTH) mq[c].push_back(wr_data[c]);
                if (popped && mq[c].size() <= DEPTH / 2) m_req[c] = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 ns later, pulses dropped.
    task automatic cycle();
        @(posedge clk_100);
        if (reset_n) model_update();
        else         model_reset();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("ch%0d sample_out", c), 32'(sample_out[c]), 32'(m_last[c]));
            check($sformatf("ch%0d sample_valid", c), 32'(sample_valid[c]), 32'(m_valid[c]));
            check($sformatf("ch%0d sound_req", c), 32'(sound_req[c]), 32'(m_req[c]));
        end
        wr_en      = '0;
        fifo_clear = '0;
        timer_ovf  = '0;
    endtask

    task automatic write_word(input int c, input logic [31:0] d);
        wr_en[c]   = 1'b1;
        wr_data[c] = d;
        cycle();
    endtask

    task automatic do_tick(input logic [1:0] ovf);
        timer_ovf = ovf;
        cycle();
    endtask

    task automatic check_all_zero(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            check({tag, " sample_out"}, 32'(sample_out[c]), 32'h0);
            check({tag, " sample_valid"}, 32'(sample_valid[c]), 32'h0);
            check({tag, " sound_req"}, 32'(sound_req[c]), 32'h0);
        end
    endtask

    logic [OUT_W-1:0] t1 [4] = '{24'h010000, 24'h020000, 24'h030000, 24'h040000};
    logic [OUT_W-1:0] t3 [4] = '{24'h200000, 24'hE00000, 24'hC00000, 24'hFF8000};

    initial begin
        int req_seen;
        int wprob;

        reset_n    = 1'b0;
        wr_en      = '0;
        wr_data    = '0;
        fifo_clear = '0;
        enable     = '0;
        timer_sel  = '0;
        timer_ovf  = '0;
        vol_full   = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        #6 reset_n = 1'b1;

        // Byte order and full-volume scaling on channel 0.
        enable    = 2'b01;
        timer_sel = 2'b00;
        vol_full  = 2'b11;
        write_word(0, 32'h04030201);
        for (int i = 0; i < 4; i++) begin
            do_tick(2'b01);
            check("t1 sample", 32'(sample_out[0]), 32'(t1[i]));
            check("t1 valid", 32'(sample_valid[0]), 32'h1);
            cycle();
        end

        // Half volume with negative bytes.
        vol_full[0] = 1'b0;
        write_word(0, 32'hFF80C040);
        for (int i = 0; i < 4; i++) begin
            do_tick(2'b01);
            check("t3 sample", 32'(sample_out[0]), 32'(t3[i]));
        end

        // Underflow after playing 0x7F re-emits it.
        vol_full[0] = 1'b1;
        write_word(0, 32'h7F000000);
        for (int i = 0; i < 4; i++) do_tick(2'b01);
        do_tick(2'b01);
        check("underflow sample", 32'(sample_out[0]), 32'h7F0000);
        check("underflow valid", 32'(sample_valid[0]), 32'h1);

        // Fill, overflow write, then drain with refill requests.
        for (int k = 0; k < DEPTH; k++) write_word(0, 32'h11111111 * (k + 1));
        write_word(0, 32'hDEADBEEF);
        req_seen = 0;
        for (int i = 0; i < 16; i++) begin
            do_tick(2'b01);
            if (sound_req[0]) req_seen++;
        end
        check("req after 4 pops", 32'(req_seen), 32'd1);
        for (int i = 0; i < 16; i++) do_tick(2'b01);
        do_tick(2'b01);
        check("dropped 9th word", 32'(sample_out[0]), 32'h880000);

        // Two channels on separate timers, then a mid-word flush on channel 1.
        enable    = 2'b11;
        timer_sel = 2'b10;
        vol_full  = 2'b11;
        wr_en     = 2'b11;
        wr_data[0] = 32'h44332211;
        wr_data[1] = 32'h88776655;
        cycle();
        do_tick(2'b11);
        do_tick(2'b11);
        check("dual ch0", 32'(sample_out[0]), 32'h220000);
        check("dual ch1", 32'(sample_out[1]), 32'h660000);
        fifo_clear[1] = 1'b1;
        timer_ovf     = 2'b10;
        cycle();
        check("clear req", 32'(sound_req[1]), 32'h1);
        check("clear beats tick", 32'(sample_valid[1]), 32'h0);
        do_tick(2'b10);
        check("cleared hold", 32'(sample_out[1]), 32'h660000);
        write_word(1, 32'h000000AB);
        do_tick(2'b10);
        check("idx reset", 32'(sample_out[1]), 32'hAB0000);
        do_tick(2'b01);
        do_tick(2'b01);

        // Randomized traffic.
        wprob = 20;
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) wprob = int'($urandom_range(40, 5));
            if (n % 128 == 0) begin
                enable    = ($urandom_range(3) == 0) ? NUM_CH'($urandom()) : '1;
                timer_sel = NUM_CH'($urandom());
                vol_full  = NUM_CH'($urandom());
            end
            for (int c = 0; c < NUM_CH; c++) begin
                wr_en[c]      = ($urandom_range(99) < wprob);
                wr_data[c]    = $urandom();
                fifo_clear[c] = ($urandom_range(99) == 0);
            end
            timer_ovf = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            cycle();
        end

        // Asynchronous reset in the middle of playback.
        enable    = 2'b11;
        timer_sel = 2'b00;
        write_word(0, 32'h12345678);
        write_word(1, 32'h9ABCDEF0);
        do_tick(2'b01);
        do_tick(2'b01);
        #3 reset_n = 1'b0;
        #1 check_all_zero("async reset");
        model_reset();
        cycle();
        cycle();
        #3 reset_n = 1'b1;
        do_tick(2'b01);
        check("post-reset ch0 sample", 32'(sample_out[0]), 32'h0);
        check("post-reset ch0 valid", 32'(sample_valid[0]), 32'h1);
        check("post-reset ch1 valid", 32'(sample_valid[1]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
